// File: rtl/z80fi_insn_packer.sv
// z80fi_insn_packer: gathers the fetched bytes of one instruction and emits a z80fi retirement packet
//
// Optional feature: define Z80FI_PACKER_ERR_EN to add the z80fi_err output.
//
// Ports:
//   clk, reset_n            core clock, asynchronous active-low reset
//   insn_start              first (M1) byte of a new instruction this cycle
//   fetch_valid, fetch_byte instruction byte strobe and value
//   retire                  current instruction completes this cycle
//   reg_a, reg_f, reg_ip    live core registers
//   z80fi_err               (Z80FI_PACKER_ERR_EN only) one-cycle violation pulse
//   z80fi_valid             one-cycle packet strobe
//   z80fi_insn, _len        packed bytes (first byte in [7:0]) and byte count
//   z80fi_reg_*_in/_out     registers at insn_start / at retire
module z80fi_insn_packer #(
    parameter int MAX_LEN = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        insn_start,
    input  logic        fetch_valid,
    input  logic [7:0]  fetch_byte,
    input  logic        retire,
    input  logic [7:0]  reg_a,
    input  logic [7:0]  reg_f,
    input  logic [15:0] reg_ip,
`ifdef Z80FI_PACKER_ERR_EN
    output logic        z80fi_err,
`endif
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [7:0]  z80fi_reg_a_in,
    output logic [7:0]  z80fi_reg_a_out,
    output logic [7:0]  z80fi_reg_f_in,
    output logic [7:0]  z80fi_reg_f_out,
    output logic [15:0] z80fi_reg_ip_in,
    output logic [15:0] z80fi_reg_ip_out
);
    typedef enum logic {IDLE, COLLECT} state_t;
    localparam logic [2:0] ML = 3'(MAX_LEN);
    state_t      state, state_nxt;
    logic [2:0]  count, cnt_eff;
    logic [31:0] byte_buf, buf_eff;
    logic [7:0]  a_snap, f_snap;
    logic [15:0] ip_snap;
    logic        collect, take, emit;
    // Buffer/count as they stand after this cycle's byte is appended; a byte
    // arriving with insn_start belongs to the new insn, never the old one.
    always_comb begin
        collect = state == COLLECT;
        take = collect && fetch_valid && !insn_start && count < ML;
        buf_eff = byte_buf;
        for (int i = 0; i < MAX_LEN; i++)
            if (take && count == 3'(i)) buf_eff[8*i +: 8] = fetch_byte;
        cnt_eff = take ? count + 3'd1 : count;
        emit = collect && retire && cnt_eff != 3'd0;
        state_nxt = insn_start ? COLLECT : (collect && retire) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= 3'd0;
            byte_buf <= 32'd0;
            a_snap   <= 8'd0;
            f_snap   <= 8'd0;
            ip_snap  <= 16'd0;
        end else if (insn_start) begin
            count    <= fetch_valid ? 3'd1 : 3'd0;
            byte_buf <= fetch_valid ? {24'd0, fetch_byte} : 32'd0;
            a_snap   <= reg_a;
            f_snap   <= reg_f;
            ip_snap  <= reg_ip;
        end else if (collect && retire) begin
            count    <= 3'd0;
            byte_buf <= 32'd0;
        end else begin
            count    <= cnt_eff;
            byte_buf <= buf_eff;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z80fi_valid      <= 1'b0;
            z80fi_insn       <= 32'd0;
            z80fi_insn_len   <= 3'd0;
            z80fi_reg_a_in   <= 8'd0;
            z80fi_reg_a_out  <= 8'd0;
            z80fi_reg_f_in   <= 8'd0;
            z80fi_reg_f_out  <= 8'd0;
            z80fi_reg_ip_in  <= 16'd0;
            z80fi_reg_ip_out <= 16'd0;
        end else begin
            z80fi_valid <= emit;
            if (emit) begin
                z80fi_insn       <= buf_eff;
                z80fi_insn_len   <= cnt_eff;
                z80fi_reg_a_in   <= a_snap;
                z80fi_reg_a_out  <= reg_a;
                z80fi_reg_f_in   <= f_snap;
                z80fi_reg_f_out  <= reg_f;
                z80fi_reg_ip_in  <= ip_snap;
                z80fi_reg_ip_out <= reg_ip;
            end
        end
    end
`ifdef Z80FI_PACKER_ERR_EN
    logic err_nxt;
    // Dropped byte (idle or buffer full) or a retire with nothing to report.
    assign err_nxt = (fetch_valid && !insn_start && (!collect || count == ML)) ||
                     (retire && (!collect || cnt_eff == 3'd0));
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) z80fi_err <= 1'b0;
        else z80fi_err <= err_nxt;
`endif
endmodule

// File: tb/tb_z80fi_insn_packer.sv
// tb_z80fi_insn_packer: randomized and directed check of z80fi_insn_packer against a queue-based model
module tb_z80fi_insn_packer;
    localparam int ML = 4;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        insn_start = 1'b0, fetch_valid = 1'b0, retire = 1'b0;
    logic [7:0]  fetch_byte = 8'd0, reg_a = 8'd0, reg_f = 8'd0;
    logic [15:0] reg_ip = 16'd0;
    logic        v;
    logic [31:0] insn;
    logic [2:0]  len;
    logic [7:0]  ai, ao, fi, fo;
    logic [15:0] ipi, ipo;
`ifdef Z80FI_PACKER_ERR_EN
    logic        err;
`endif
    z80fi_insn_packer #(.MAX_LEN(ML)) dut (
        .clk(clk), .reset_n(reset_n), .insn_start(insn_start),
        .fetch_valid(fetch_valid), .fetch_byte(fetch_byte), .retire(retire),
        .reg_a(reg_a), .reg_f(reg_f), .reg_ip(reg_ip),
`ifdef Z80FI_PACKER_ERR_EN
        .z80fi_err(err),
`endif
        .z80fi_valid(v), .z80fi_insn(insn), .z80fi_insn_len(len),
        .z80fi_reg_a_in(ai), .z80fi_reg_a_out(ao),
        .z80fi_reg_f_in(fi), .z80fi_reg_f_out(fo),
        .z80fi_reg_ip_in(ipi), .z80fi_reg_ip_out(ipo)
    );
    always #5 clk = ~clk;
    int errors = 0, checks = 0;
    // Model: open flag, byte queue of the open insn, start snapshot, and the
    // expected (held) packet outputs.
    bit          m_open;
    logic [7:0]  m_q[$];
    logic [7:0]  m_a, m_f;
    logic [15:0] m_ip;
    logic        e_v, e_err;
    logic [31:0] e_insn;
    logic [2:0]  e_len;
    logic [7:0]  e_ai, e_ao, e_fi, e_fo;
    logic [15:0] e_ipi, e_ipo;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset;
        m_open = 0; m_q.delete();
        e_v = 0; e_err = 0; e_insn = 0; e_len = 0;
        e_ai = 0; e_ao = 0; e_fi = 0; e_fo = 0; e_ipi = 0; e_ipo = 0;
    endtask
    task automatic model_step;
        bit ev = 0, ee = 0;
        bit nb = fetch_valid && !insn_start;
        if (retire) begin
            if (m_open) begin
                if (nb) begin
                    if (m_q.size() < ML) m_q.push_back(fetch_byte);
                    else ee = 1;
                end
                if (m_q.size() > 0) begin
                    ev = 1;
                    e_insn = 0;
                    foreach (m_q[i]) e_insn[8*i +: 8] = m_q[i];
                    e_len = 3'(m_q.size());
                    e_ai = m_a; e_fi = m_f; e_ipi = m_ip;
                    e_ao = reg_a; e_fo = reg_f; e_ipo = reg_ip;
                end else ee = 1;
                m_open = 0; m_q.delete();
            end else ee = 1;
        end else if (nb) begin
            if (m_open && m_q.size() < ML) m_q.push_back(fetch_byte);
            else ee = 1;
        end
        if (insn_start) begin
            m_open = 1; m_q.delete();
            if (fetch_valid) m_q.push_back(fetch_byte);
            m_a = reg_a; m_f = reg_f; m_ip = reg_ip;
        end
        e_v = ev; e_err = ee;
    endtask
    task automatic compare_all;
        chk("valid", 32'(v), 32'(e_v));
        chk("insn", insn, e_insn);
        chk("len", 32'(len), 32'(e_len));
        chk("a_in", 32'(ai), 32'(e_ai));
        chk("a_out", 32'(ao), 32'(e_ao));
        chk("f_in", 32'(fi), 32'(e_fi));
        chk("f_out", 32'(fo), 32'(e_fo));
        chk("ip_in", 32'(ipi), 32'(e_ipi));
        chk("ip_out", 32'(ipo), 32'(e_ipo));
`ifdef Z80FI_PACKER_ERR_EN
        chk("err", 32'(err), 32'(e_err));
`endif
    endtask
    task automatic step(input bit st, input bit fv, input logic [7:0] b, input bit rt,
                        input logic [7:0] a, input logic [7:0] f, input logic [15:0] ip);
        @(negedge clk);
        insn_start = st; fetch_valid = fv; fetch_byte = b; retire = rt;
        reg_a = a; reg_f = f; reg_ip = ip;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask
    task automatic rs(input bit st, input bit fv, input logic [7:0] b, input bit rt);
        step(st, fv, b, rt, 8'($urandom), 8'($urandom), 16'($urandom));
    endtask
    task automatic do_reset;
        @(negedge clk);
        reset_n = 0;
        insn_start = 0; fetch_valid = 0; retire = 0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset_n = 1;
    endtask
    task automatic lit_err(input string name, input logic exp);
`ifdef Z80FI_PACKER_ERR_EN
        chk(name, 32'(err), 32'(exp));
`endif
    endtask
    initial begin
        do_reset();
        chk("reset_valid", 32'(v), 32'd0);
        chk("reset_insn", insn, 32'd0);
        // NEG
        step(1, 1, 8'hED, 0, 8'h01, 8'h00, 16'h0100);
        step(0, 1, 8'h44, 0, 8'h55, 8'h66, 16'h0101);
        step(0, 0, 8'h00, 1, 8'hFF, 8'hBB, 16'h0102);
        chk("neg_valid", 32'(v), 32'd1);
        chk("neg_insn", insn, 32'h000044ED);
        chk("neg_len", 32'(len), 32'd2);
        chk("neg_a_in", 32'(ai), 32'h01);
        chk("neg_a_out", 32'(ao), 32'hFF);
        chk("neg_ip_in", 32'(ipi), 32'h0100);
        chk("neg_ip_out", 32'(ipo), 32'h0102);
        rs(0, 0, 8'h00, 0);
        chk("neg_strobe", 32'(v), 32'd0);
        chk("neg_hold", insn, 32'h000044ED);
        // Back-to-back
        rs(1, 1, 8'h00, 0);
        rs(1, 1, 8'h3E, 1);
        chk("b2b_valid", 32'(v), 32'd1);
        chk("b2b_insn", insn, 32'h00000000);
        chk("b2b_len", 32'(len), 32'd1);
        rs(0, 0, 8'h00, 1);
        chk("b2b2_valid", 32'(v), 32'd1);
        chk("b2b2_insn", insn, 32'h0000003E);
        // Overflow
        rs(1, 1, 8'hDD, 0);
        rs(0, 1, 8'hCB, 0);
        rs(0, 1, 8'h05, 0);
        rs(0, 1, 8'h46, 0);
        lit_err("ovf_no_err", 1'b0);
        rs(0, 1, 8'h77, 0);
        lit_err("ovf_err", 1'b1);
        rs(0, 0, 8'h00, 1);
        lit_err("ovf_err_once", 1'b0);
        chk("ovf_insn", insn, 32'h4605CBDD);
        chk("ovf_len", 32'(len), 32'd4);
        // Orphan retire
        rs(0, 0, 8'h00, 0);
        rs(0, 0, 8'h00, 1);
        chk("orphan_valid", 32'(v), 32'd0);
        lit_err("orphan_err", 1'b1);
        // Reset mid-insn
        rs(1, 1, 8'hAA, 0);
        rs(0, 1, 8'hBB, 0);
        do_reset();
        rs(1, 1, 8'h3E, 0);
        rs(0, 1, 8'h12, 0);
        rs(0, 0, 8'h00, 1);
        chk("rst_insn", insn, 32'h0000123E);
        chk("rst_len", 32'(len), 32'd2);
        // Byte on the retire cycle
        rs(1, 1, 8'hC3, 0);
        rs(0, 1, 8'h00, 0);
        rs(0, 1, 8'h20, 1);
        chk("jp_insn", insn, 32'h002000C3);
        chk("jp_len", 32'(len), 32'd3);
        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else rs($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                    8'($urandom), $urandom_range(0, 4) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
